// File: rtl/photon_pkg.sv
// Shared constants for the photon timing chain (free-running counter and its consumers).
package photon_pkg;

    localparam int TS_WIDTH_DEF    = 32;
    localparam int FIFO_DEPTH_DEF  = 8;
    localparam int LOST_WIDTH_DEF  = 8;
    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on rdata while !empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wptr;
    logic [AW:0]                 rptr;
    logic                        do_push;
    logic                        do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = wptr - rptr;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr[AW-1:0]];

    // Storage is cleared on reset so rdata reads 0 until the first write.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop)
                rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/hit_timestamper.sv
// Synchronizes a discriminator hit, tags rising edges with the counter value and queues them.
module hit_timestamper
    import photon_pkg::*;
#(
    parameter int TS_WIDTH    = TS_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_MIN,
    parameter int LOST_WIDTH  = LOST_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic [TS_WIDTH-1:0]           count_in,
    input  logic                          hit_async,
    input  logic                          en,
    output logic [TS_WIDTH-1:0]           ts_data,
    output logic                          ts_valid,
    input  logic                          ts_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [LOST_WIDTH-1:0]         lost_cnt,
    input  logic                          clr_lost
);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   hit_s;
    logic                   hit_s_d;
    logic                   armed;
    logic                   hit_e;
    logic                   capture;
    logic                   full;
    logic                   empty;
    logic                   drop;

    assign hit_s = sync[SYNC_STAGES-1];

    // fill marks when hit_s carries a real post-reset sample; armed then waits for a low,
    // so a hit already high at reset release never looks like an edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync    <= '0;
            fill    <= '0;
            hit_s_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], hit_async};
            fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
            hit_s_d <= hit_s;
            if (fill[SYNC_STAGES-1] && !hit_s)
                armed <= 1'b1;
        end
    end

    assign hit_e   = hit_s & ~hit_s_d & armed;
    assign capture = hit_e & en;
    assign drop    = capture & full;

    // Saturating drop counter; a clear coinciding with a drop leaves exactly that drop.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            lost_cnt <= '0;
        else if (clr_lost)
            lost_cnt <= LOST_WIDTH'(drop);
        else if (drop && (lost_cnt != {LOST_WIDTH{1'b1}}))
            lost_cnt <= lost_cnt + 1'b1;
    end

    sync_fifo_fwft #(
        .WIDTH (TS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (capture),
        .wdata (count_in),
        .pop   (ts_ready),
        .rdata (ts_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign ts_valid = ~empty;

endmodule
